// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer: FSM state encoding,
// ALU op codes and the captured-flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } seq_state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  localparam int unsigned FLG_CAR = 1;
  localparam int unsigned FLG_OF  = 0;

endpackage

// File: rtl/alu_op_sequencer_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stability counter and a one-cycle
// pulse on the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DB_CNT_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  logic                sync1_q, sync2_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                press_q, press_d;

  // The level flips on the DB_CYCLES-th consecutive cycle of disagreement.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q >= DB_CNT_W'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Switch-driven front-end for the 4-bit ALU: A, B, op per button press, then a
// settle window and a held capture of res/car/of. Option: ALU_SEQ_CHAIN_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned DB_CNT_W      = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic [2:0] op_sw,
  input  logic       btn,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [3:0] alu_res,
  input  logic       alu_car,
  input  logic       alu_of,
  output logic [3:0] res_q,
  output logic [1:0] flags_q,
  output logic       out_valid,
  output logic [2:0] state_o
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic db_level, db_press, press;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_CNT_W  (DB_CNT_W)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn),
    .level_o (db_level),
    .press_o (db_press)
  );

  assign press = db_press & db_level;

  seq_state_e       state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [3:0]       cap_res_q, cap_res_d;
  logic [1:0]       cap_flags_q, cap_flags_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    settle_d    = settle_q;
    cap_res_d   = cap_res_q;
    cap_flags_d = cap_flags_q;
    valid_d     = valid_q;
    unique case (state_q)
      S_A: if (press) begin
        a_d     = sw;
        state_d = S_B;
      end
      S_B: if (press) begin
        b_d     = sw;
        state_d = S_OP;
      end
      S_OP: if (press) begin
        ctrl_d   = op_sw;
        settle_d = '0;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          cap_res_d           = alu_res;
          cap_flags_d[FLG_CAR] = alu_car;
          cap_flags_d[FLG_OF]  = alu_of;
          valid_d             = 1'b1;
          state_d             = S_SHOW;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_SHOW: if (press) begin
        valid_d = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        // sw == F feeds the held result back in as the next operand A.
        if (sw == 4'hF) begin
          a_d     = cap_res_q;
          state_d = S_B;
        end else begin
          state_d = S_A;
        end
`else
        state_d = S_A;
`endif
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      settle_q    <= '0;
      cap_res_q   <= '0;
      cap_flags_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      settle_q    <= settle_d;
      cap_res_q   <= cap_res_d;
      cap_flags_q <= cap_flags_d;
      valid_q     <= valid_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = ctrl_q;
  assign res_q     = cap_res_q;
  assign flags_q   = cap_flags_q;
  assign out_valid = valid_q;
  assign state_o   = state_q;

endmodule
